// File: rtl/offset_add_arb_pkg.sv
// Shared types and constants for the offset-add arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package offset_add_arb_pkg;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/offset_add_arb_if.sv
// Request/response bundle between requesters/consumer and the offset-add arbiter.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls grants while a result is held.
interface offset_add_arb_if;
    import offset_add_arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [NUM_CH-1:0] gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ready;
    logic [DATA_W-1:0] txn_cnt;

    // Requesters plus downstream consumer side.
    modport master (
        output req, din0, din1, din2, out_ready,
        input  gnt, out_valid, out_data, out_ch, txn_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, din0, din1, din2, out_ready,
        output gnt, out_valid, out_data, out_ch, txn_cnt
    );
endinterface

// File: rtl/offset_add_arb_rr_arb3.sv
// Three-way round-robin grant: search starts at last+1 and wraps 2->0.
// Latency: combinational.
// Backpressure: none here; the caller masks the grant when it cannot accept.
module rr_arb3
    import offset_add_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] gnt
);

    // Priority rotates so the channel after the last winner is checked first.
    always_comb begin
        gnt = '0;
        case (last)
            2'd0: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            // last=2 (and the unreachable 3) start the search at channel 0.
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/offset_add_arb.sv
// Round-robin arbiter feeding one shared adder that adds a per-channel constant offset.
// Latency: 1 cycle from gnt to registered result.
// Backpressure: result held and gnt suppressed while FULL and out_ready=0; no bubble on accept.
module offset_add_arb
    import offset_add_arb_pkg::*;
#(
    parameter int P_BASE  = 23,
    parameter int P_LOCAL = 42
) (
    input  logic            clk,
    input  logic            rst,
    offset_add_arb_if.slave bus
);

    // Offsets fold to 8 bits at elaboration; the adder wraps modulo 256.
    localparam logic [DATA_W-1:0] OFF0 = DATA_W'(P_LOCAL);
    localparam logic [DATA_W-1:0] OFF1 = DATA_W'(P_BASE + P_LOCAL);
    localparam logic [DATA_W-1:0] OFF2 = DATA_W'(P_BASE);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] txn_cnt_q, txn_cnt_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [NUM_CH-1:0] gnt;
    logic              slot;
    logic              consume;
    logic [DATA_W-1:0] sel_din;
    logic [DATA_W-1:0] sel_off;
    logic [CH_W-1:0]   sel_idx;

    rr_arb3 u_arb (
        .req  (bus.req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Accept slot, grant masking and shared-adder operand selection.
    always_comb begin
        slot    = (state_q == EMPTY) || bus.out_ready;
        gnt     = (slot && !rst) ? arb_gnt : '0;
        consume = (state_q == FULL) && bus.out_ready;
        sel_din = bus.din0;
        sel_off = OFF0;
        sel_idx = 2'd0;
        if (gnt[1]) begin
            sel_din = bus.din1;
            sel_off = OFF1;
            sel_idx = 2'd1;
        end else if (gnt[2]) begin
            sel_din = bus.din2;
            sel_off = OFF2;
            sel_idx = 2'd2;
        end
    end

    // Next-state: load on grant, drain when consumed without a refill.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        last_d     = last_q;
        txn_cnt_d  = txn_cnt_q + (consume ? 8'd1 : 8'd0);
        if (|gnt) begin
            state_d    = FULL;
            out_data_d = sel_din + sel_off;
            out_ch_d   = sel_idx;
            last_d     = sel_idx;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    // Registers with synchronous reset; last=2 gives channel 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            last_q     <= 2'd2;
            txn_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            last_q     <= last_d;
            txn_cnt_q  <= txn_cnt_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.txn_cnt   = txn_cnt_q;

endmodule
